// File: rtl/stack_pkg.sv
// Shared constants for the stack sequencer, its datapath and benches:
// stack commands, write-mux selects, opcodes, FSM states and error codes.
package stack_pkg;

  localparam logic [2:0] STK_NOP  = 3'd0;
  localparam logic [2:0] STK_PUSH = 3'd1;
  localparam logic [2:0] STK_POP  = 3'd2;
  localparam logic [2:0] STK_ALU  = 3'd3;

  localparam logic [2:0] MUX_ALU = 3'd0;
  localparam logic [2:0] MUX_IMM = 3'd1;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_PUSHI = 4'h1;
  localparam logic [3:0] OP_PUSHW = 4'h2;
  localparam logic [3:0] OP_POP   = 4'h3;
  localparam logic [3:0] OP_ALU   = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
  localparam logic [1:0] ERR_ALU       = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_FETCH2, S_EXEC, S_HALT, S_ERROR
  } state_t;

endpackage

// File: rtl/stack_seq_decode.sv
// Combinational decode of the latched instruction: stack/ALU command,
// write-mux select, literal, next pc and next depth, plus fault detection.
// A faulting instruction yields STK_NOP and leaves pc/depth unchanged.
module stack_seq_decode
  import stack_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 16,
  parameter int DEPTH_W = 5
) (
  input  logic [15:0]        ir,
  input  logic [15:0]        lit,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [DEPTH_W-1:0] depth,
  output logic [2:0]         stk_op,
  output logic [3:0]         alu_op,
  output logic [2:0]         mux_sel,
  output logic [15:0]        imm,
  output logic [ADDR_W-1:0]  pc_next,
  output logic [DEPTH_W-1:0] depth_next,
  output logic               is_halt,
  output logic               fault,
  output logic [1:0]         fault_code
);

  logic full, has_one, has_two;

  assign full    = (depth == DEPTH_W'(DEPTH));
  assign has_one = (depth != '0);
  assign has_two = (depth >= DEPTH_W'(2));

  // opcode decode with fault checks ahead of issue
  always_comb begin
    stk_op     = STK_NOP;
    alu_op     = '0;
    mux_sel    = MUX_ALU;
    imm        = '0;
    pc_next    = pc + ADDR_W'(1);
    depth_next = depth;
    is_halt    = 1'b0;
    fault      = 1'b0;
    fault_code = ERR_NONE;
    case (ir[15:12])
      OP_PUSHI, OP_PUSHW: begin
        if (full) begin
          fault      = 1'b1;
          fault_code = ERR_OVERFLOW;
          pc_next    = pc;
        end else begin
          stk_op     = STK_PUSH;
          mux_sel    = MUX_IMM;
          imm        = (ir[15:12] == OP_PUSHW) ? lit : {4'h0, ir[11:0]};
          depth_next = depth + DEPTH_W'(1);
          if (ir[15:12] == OP_PUSHW) pc_next = pc + ADDR_W'(2);
        end
      end
      OP_POP: begin
        if (!has_one) begin
          fault      = 1'b1;
          fault_code = ERR_UNDERFLOW;
          pc_next    = pc;
        end else begin
          stk_op     = STK_POP;
          depth_next = depth - DEPTH_W'(1);
        end
      end
      OP_ALU: begin
        if (!has_two) begin
          fault      = 1'b1;
          fault_code = ERR_UNDERFLOW;
          pc_next    = pc;
        end else begin
          stk_op     = STK_ALU;
          alu_op     = ir[3:0];
          depth_next = depth - DEPTH_W'(1);
        end
      end
      OP_JMP:  pc_next = ir[ADDR_W-1:0];
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/stack_sequencer.sv
// Instruction-level controller for the register-stack/ALU datapath.
// Fetches one or two words per instruction, then issues one command in EXEC.
// Build option: OVERFLOW_TRAP_EN makes an ALU op with overflow_in high
// write its result and then stop in ERROR with err_code 3.
//
// state    | meaning
// S_IDLE   | waiting for start, pc held at 0
// S_FETCH  | request instruction word at pc
// S_FETCH2 | request PUSHW literal at pc+1
// S_EXEC   | one cycle: issue command, update pc/depth
// S_HALT   | HALT executed, sticky until reset
// S_ERROR  | fault trapped, err_code valid, sticky until reset
module stack_sequencer
  import stack_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 16,
  parameter int DEPTH_W = 5
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               start,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [15:0]        imem_rdata,
  input  logic               overflow_in,
  output logic [2:0]         stackOP,
  output logic [3:0]         aluOP,
  output logic [15:0]        immediate,
  output logic [2:0]         mux_selector,
  output logic [DEPTH_W-1:0] depth,
  output logic               busy,
  output logic               halted,
  output logic               error,
  output logic [1:0]         err_code
);

  state_t state, state_nxt;
  logic [ADDR_W-1:0]  pc;
  logic [DEPTH_W-1:0] depth_q;
  logic [15:0]        ir, lit;
  logic [1:0]         err_q;

  logic [2:0]         dec_stk, dec_mux;
  logic [3:0]         dec_alu;
  logic [15:0]        dec_imm;
  logic [ADDR_W-1:0]  dec_pc_next;
  logic [DEPTH_W-1:0] dec_depth_next;
  logic               dec_halt, dec_fault, trap_alu;
  logic [1:0]         dec_fault_code;

  stack_seq_decode #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) u_decode (
    .ir(ir), .lit(lit), .pc(pc), .depth(depth_q),
    .stk_op(dec_stk), .alu_op(dec_alu), .mux_sel(dec_mux), .imm(dec_imm),
    .pc_next(dec_pc_next), .depth_next(dec_depth_next),
    .is_halt(dec_halt), .fault(dec_fault), .fault_code(dec_fault_code)
  );

`ifdef OVERFLOW_TRAP_EN
  assign trap_alu = (ir[15:12] == OP_ALU) && !dec_fault && overflow_in;
`else
  logic unused_overflow;
  assign unused_overflow = overflow_in;
  assign trap_alu        = 1'b0;
`endif

  assign depth    = depth_q;
  assign err_code = err_q;

  // state register
  always_ff @(posedge CLK) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state and per-state outputs; commands only leave the block in EXEC
  always_comb begin
    state_nxt    = state;
    imem_req     = 1'b0;
    imem_addr    = '0;
    stackOP      = STK_NOP;
    aluOP        = '0;
    immediate    = '0;
    mux_selector = MUX_ALU;
    busy         = 1'b0;
    halted       = 1'b0;
    error        = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        busy      = 1'b1;
        imem_req  = 1'b1;
        imem_addr = pc;
        if (imem_valid)
          state_nxt = (imem_rdata[15:12] == OP_PUSHW) ? S_FETCH2 : S_EXEC;
      end
      S_FETCH2: begin
        busy      = 1'b1;
        imem_req  = 1'b1;
        imem_addr = pc + ADDR_W'(1);
        if (imem_valid) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        busy         = 1'b1;
        stackOP      = dec_stk;
        aluOP        = dec_alu;
        immediate    = dec_imm;
        mux_selector = dec_mux;
        if (dec_fault)     state_nxt = S_ERROR;
        else if (dec_halt) state_nxt = S_HALT;
        else if (trap_alu) state_nxt = S_ERROR;
        else               state_nxt = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      S_ERROR: error  = 1'b1;
      default: state_nxt = S_IDLE;
    endcase
  end

  // pc, depth, fetched words and error code
  always_ff @(posedge CLK) begin
    if (!reset) begin
      pc      <= '0;
      depth_q <= '0;
      ir      <= '0;
      lit     <= '0;
      err_q   <= ERR_NONE;
    end else begin
      case (state)
        S_IDLE:   if (start) pc <= '0;
        S_FETCH:  if (imem_valid) ir <= imem_rdata;
        S_FETCH2: if (imem_valid) lit <= imem_rdata;
        S_EXEC: begin
          if (dec_fault) begin
            err_q <= dec_fault_code;
          end else begin
            pc      <= dec_pc_next;
            depth_q <= dec_depth_next;
            if (trap_alu) err_q <= ERR_ALU;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: directed programs load an instruction
// memory model; expected fetch addresses and EXEC commands are queued up front
// and checked by independent responder and monitor processes.
module tb_stack_sequencer;
  import stack_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int DEPTH   = 16;
  localparam int DEPTH_W = 5;

  logic               CLK = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic               imem_valid = 1'b0;
  logic [15:0]        imem_rdata = '0;
  logic               overflow_in = 1'b0;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [2:0]         stackOP;
  logic [3:0]         aluOP;
  logic [15:0]        immediate;
  logic [2:0]         mux_selector;
  logic [DEPTH_W-1:0] depth;
  logic               busy, halted, error;
  logic [1:0]         err_code;

  stack_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
    .CLK(CLK), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .overflow_in(overflow_in),
    .stackOP(stackOP), .aluOP(aluOP), .immediate(immediate),
    .mux_selector(mux_selector), .depth(depth),
    .busy(busy), .halted(halted), .error(error), .err_code(err_code)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0]         stk;
    logic [3:0]         alu;
    logic [2:0]         mux;
    logic [15:0]        imm;
    logic [DEPTH_W-1:0] dep;
  } exec_t;

  exec_t             exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  logic [15:0]       mem [0:255];
  int                n_tests = 0;
  int                n_fail = 0;
  int                mem_delay = 0;
  int                wait_cnt = 0;
  logic [ADDR_W-1:0] req_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exec(input logic [2:0] stk, input logic [3:0] alu, input logic [2:0] mux,
                           input logic [15:0] imm, input int dep);
    exec_t e;
    e.stk = stk; e.alu = alu; e.mux = mux; e.imm = imm; e.dep = DEPTH_W'(dep);
    exp_q.push_back(e);
  endtask

  function automatic logic [63:0] all_outs();
    return {imem_req, imem_addr, stackOP, aluOP, immediate, mux_selector,
            depth, busy, halted, error, err_code};
  endfunction

  // instruction memory responder: grants after mem_delay wait cycles
  initial forever begin
    @(negedge CLK);
    if (!reset) begin
      imem_valid = 1'b0;
      wait_cnt   = 0;
    end else if (imem_valid) begin
      imem_valid = 1'b0;
      wait_cnt   = 0;
    end else if (imem_req) begin
      if (wait_cnt == 0) req_addr = imem_addr;
      else check("addr_stable", imem_addr, req_addr);
      if (wait_cnt >= mem_delay) begin
        if (addr_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL fetch_addr: unexpected fetch at %0h", imem_addr);
        end else begin
          check("fetch_addr", imem_addr, addr_q.pop_front());
        end
        imem_rdata = mem[imem_addr];
        imem_valid = 1'b1;
        wait_cnt   = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  // EXEC monitor: busy without a fetch request marks the issue cycle
  initial forever begin
    @(negedge CLK);
    if (reset && busy && !imem_req) begin
      exec_t e;
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL exec: unexpected command stk=%0d depth=%0d", stackOP, depth);
      end else begin
        e = exp_q.pop_front();
        check("exec_stackOP", stackOP, e.stk);
        check("exec_aluOP", aluOP, e.alu);
        check("exec_mux", mux_selector, e.mux);
        check("exec_imm", immediate, e.imm);
        check("exec_depth", depth, e.dep);
      end
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b0; start = 1'b0; overflow_in = 1'b0; mem_delay = 0;
    repeat (2) @(negedge CLK);
    exp_q.delete();
    addr_q.delete();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    reset = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
  endtask

  task automatic run_prog(input string name, input int budget);
    int cyc = 0;
    pulse_start();
    while (!(halted || error) && cyc < budget) begin
      @(negedge CLK);
      cyc++;
    end
    if (!(halted || error)) begin
      n_tests++; n_fail++;
      $display("FAIL %s: no halt/error within %0d cycles", name, budget);
    end
    repeat (2) @(negedge CLK);
    check({name, "_exec_left"}, exp_q.size(), 0);
    check({name, "_fetch_left"}, addr_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    do_reset();
    check("reset_outs", all_outs(), 64'd0);

    // PUSHI 5, PUSHI 3, ALU op 1, HALT
    do_reset();
    mem[0] = 16'h1005; mem[1] = 16'h1003; mem[2] = 16'h4001; mem[3] = 16'hF000;
    for (int i = 0; i < 4; i++) addr_q.push_back(ADDR_W'(i));
    push_exec(STK_PUSH, 4'd0, MUX_IMM, 16'd5, 0);
    push_exec(STK_PUSH, 4'd0, MUX_IMM, 16'd3, 1);
    push_exec(STK_ALU,  4'd1, MUX_ALU, 16'd0, 2);
    push_exec(STK_NOP,  4'd0, MUX_ALU, 16'd0, 1);
    run_prog("basic", 60);
    check("basic_halted", {halted, error, busy}, 3'b100);
    check("basic_depth", depth, 1);

    // PUSHW literal, then POP, HALT
    do_reset();
    mem[0] = 16'h2000; mem[1] = 16'hBEEF; mem[2] = 16'h3000; mem[3] = 16'hF000;
    for (int i = 0; i < 4; i++) addr_q.push_back(ADDR_W'(i));
    push_exec(STK_PUSH, 4'd0, MUX_IMM, 16'hBEEF, 0);
    push_exec(STK_POP,  4'd0, MUX_ALU, 16'd0, 1);
    push_exec(STK_NOP,  4'd0, MUX_ALU, 16'd0, 0);
    run_prog("pushw", 60);
    check("pushw_halted", halted, 1);
    check("pushw_depth", depth, 0);

    // POP on empty stack, start afterwards ignored
    do_reset();
    mem[0] = 16'h3000;
    addr_q.push_back(ADDR_W'(0));
    push_exec(STK_NOP, 4'd0, MUX_ALU, 16'd0, 0);
    run_prog("underflow", 40);
    check("underflow_err", {error, err_code}, 3'b101);
    check("underflow_depth", depth, 0);
    pulse_start();
    repeat (3) @(negedge CLK);
    check("underflow_sticky", {error, busy, imem_req, halted}, 4'b1000);

    // 17 PUSHI into a 16-entry stack
    do_reset();
    for (int i = 0; i < 17; i++) begin
      mem[i] = 16'h1000 | 16'(i);
      addr_q.push_back(ADDR_W'(i));
      if (i < 16) push_exec(STK_PUSH, 4'd0, MUX_IMM, 16'(i), i);
      else        push_exec(STK_NOP, 4'd0, MUX_ALU, 16'd0, 16);
    end
    run_prog("overflow", 200);
    check("overflow_err", {error, err_code}, 3'b110);
    check("overflow_depth", depth, 16);

    // JMP 0x0FF, NOP at 0xFF wraps pc to 0; loop ends on stack overflow
    do_reset();
    mem[0] = 16'h1001; mem[1] = 16'h50FF; mem[255] = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      addr_q.push_back(8'h00); addr_q.push_back(8'h01); addr_q.push_back(8'hFF);
      push_exec(STK_PUSH, 4'd0, MUX_IMM, 16'd1, k);
      push_exec(STK_NOP,  4'd0, MUX_ALU, 16'd0, k + 1);
      push_exec(STK_NOP,  4'd0, MUX_ALU, 16'd0, k + 1);
    end
    addr_q.push_back(8'h00);
    push_exec(STK_NOP, 4'd0, MUX_ALU, 16'd0, 16);
    run_prog("jmp_wrap", 600);
    check("jmp_wrap_err", {error, err_code}, 3'b110);

    // ALU with overflow_in asserted
    do_reset();
    overflow_in = 1'b1;
    mem[0] = 16'h1001; mem[1] = 16'h1002; mem[2] = 16'h4002; mem[3] = 16'hF000;
    for (int i = 0; i < 3; i++) addr_q.push_back(ADDR_W'(i));
    push_exec(STK_PUSH, 4'd0, MUX_IMM, 16'd1, 0);
    push_exec(STK_PUSH, 4'd0, MUX_IMM, 16'd2, 1);
    push_exec(STK_ALU,  4'd2, MUX_ALU, 16'd0, 2);
`ifdef OVERFLOW_TRAP_EN
    run_prog("alu_trap", 60);
    check("alu_trap_err", {error, halted, err_code}, 4'b1011);
`else
    addr_q.push_back(ADDR_W'(3));
    push_exec(STK_NOP, 4'd0, MUX_ALU, 16'd0, 1);
    run_prog("alu_trap", 60);
    check("alu_trap_err", {error, halted, err_code}, 4'b0100);
`endif
    check("alu_trap_depth", depth, 1);

    // delayed imem_valid: request and address must hold while waiting
    do_reset();
    mem_delay = 3;
    mem[0] = 16'h1009; mem[1] = 16'hF000;
    addr_q.push_back(ADDR_W'(0)); addr_q.push_back(ADDR_W'(1));
    push_exec(STK_PUSH, 4'd0, MUX_IMM, 16'd9, 0);
    push_exec(STK_NOP,  4'd0, MUX_ALU, 16'd0, 1);
    run_prog("delay", 60);
    check("delay_halted", halted, 1);

    // reset mid-wait abandons the fetch
    do_reset();
    mem_delay = 50;
    mem[0] = 16'h1009;
    pulse_start();
    repeat (4) @(negedge CLK);
    check("midwait_req", {imem_req, busy}, 2'b11);
    reset = 1'b0;
    @(negedge CLK);
    check("midwait_reset_outs", all_outs(), 64'd0);
    reset = 1'b1;
    mem_delay = 0;
    repeat (3) @(negedge CLK);
    check("midwait_idle", {busy, imem_req, depth}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
